// File: rtl/pwm_seq_ctrl.sv
// Sequencer for the modulo-FIN_CUENTA up/down counter of the PWM generator.
// Latency: oCNT_EN/oCNT_UP combinational from state; oPWM/oPERIOD one clock after the count.
// Backpressure: duty valid/ready; one pending write is held until the next period boundary.
//
// Ports:
//   iCLK, iRST_n          clock (posedge) and asynchronous active-low reset
//   iSTART / iSTOP        start pulse (IDLE only) / stop pulse (running only, takes effect at boundary)
//   iMODE                 0 edge-aligned sawtooth, 1 center-aligned triangle; latched at start
//   iDUTY, iDUTY_VALID    duty write request; oDUTY_READY high while the shadow register is free
//   iCOUNT                value returned by the attached counter
//   oCNT_EN, oCNT_UP      counter step enable (one-clock pulse) and direction
//   oPWM                  registered PWM output; oPERIOD one-clock pulse after each boundary
//   oBUSY                 high while not IDLE
//   oPWM_N                complementary output with dead time, present only with PWM_DEADTIME_EN

package pwm_seq_pkg;
  // ceil(log2(value)); returns 0 for value <= 1
  function automatic int CLogB2(input int value);
    int res;
    int v;
    res = 0;
    v = value - 1;
    while (v > 0) begin
      res = res + 1;
      v = v >> 1;
    end
    return res;
  endfunction
endpackage

module pwm_seq_ctrl
  import pwm_seq_pkg::*;
#(
  parameter int FIN_CUENTA = 20,
  parameter int PRESCALER  = 4,
  parameter int DT_CYCLES  = 2,
  localparam int N         = CLogB2(FIN_CUENTA - 1)
) (
  input  logic         iCLK,
  input  logic         iRST_n,
  input  logic         iSTART,
  input  logic         iSTOP,
  input  logic         iMODE,
  input  logic [N:0]   iDUTY,
  input  logic         iDUTY_VALID,
  output logic         oDUTY_READY,
  input  logic [N-1:0] iCOUNT,
  output logic         oCNT_EN,
  output logic         oCNT_UP,
  output logic         oPWM,
  output logic         oPERIOD,
  output logic         oBUSY
`ifdef PWM_DEADTIME_EN
  ,
  output logic         oPWM_N
`endif
);

  localparam int PW = (CLogB2(PRESCALER) > 0) ? CLogB2(PRESCALER) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALER - 1);
  localparam logic [N-1:0]  CNT_TOP    = N'(FIN_CUENTA - 1);
  localparam logic [N-1:0]  CNT_TURN   = N'(FIN_CUENTA - 2);
  localparam logic [N-1:0]  CNT_ONE    = N'(1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN_UP   = 2'd1,
    RUN_DOWN = 2'd2
  } state_t;

  state_t        state;
  logic [PW-1:0] presc;
  logic          modeCenter;
  logic          stopReq;
  logic          pending;
  logic [N:0]    activeDuty;
  logic [N:0]    shadowDuty;

  logic running;
  logic tick;
  logic boundary;
  logic turnDown;
  logic dutyXfer;
  logic dutyMove;
  logic cmpHigh;
  logic pwmNext;

  always_comb begin
    running  = (state != IDLE);
    tick     = running && (presc == PRESC_LAST);
    // Edge mode wraps at the top count; center mode closes the period on the
    // down-step from 1 to 0.
    if (modeCenter) begin
      boundary = tick && (state == RUN_DOWN) && (iCOUNT == CNT_ONE);
    end else begin
      boundary = tick && (iCOUNT == CNT_TOP);
    end
    // Turn one step early: the counter reaches the top on this tick, and the
    // next tick must already count down.
    turnDown = tick && modeCenter && (state == RUN_UP) && (iCOUNT == CNT_TURN);
    dutyXfer = iDUTY_VALID && oDUTY_READY;
    dutyMove = pending && (!running || boundary);
    cmpHigh  = ({1'b0, iCOUNT} < activeDuty);
    pwmNext  = running && cmpHigh;
  end

  assign oCNT_EN     = tick;
  assign oCNT_UP     = (state != RUN_DOWN);
  assign oBUSY       = running;
  assign oDUTY_READY = ~pending;

  // Sequencer: state, prescaler, stop request and period pulse.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state      <= IDLE;
      presc      <= '0;
      modeCenter <= 1'b0;
      stopReq    <= 1'b0;
      oPERIOD    <= 1'b0;
    end else begin
      oPERIOD <= boundary;
      case (state)
        IDLE: begin
          if (iSTART) begin
            modeCenter <= iMODE;
            presc      <= '0;
            state      <= RUN_UP;
          end
        end
        default: begin
          presc <= tick ? '0 : presc + PW'(1);
          if (boundary && stopReq) begin
            // Counter lands on 0 with this step, so IDLE always starts from 0.
            state   <= IDLE;
            stopReq <= 1'b0;
          end else begin
            if (iSTOP) stopReq <= 1'b1;
            if (turnDown) begin
              state <= RUN_DOWN;
            end else if (boundary) begin
              state <= RUN_UP;
            end
          end
        end
      endcase
    end
  end

  // Duty double buffer. Ready is the inverse of pending, so a write arriving
  // on a boundary clock is refused while the older value moves to active.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      activeDuty <= '0;
      shadowDuty <= '0;
      pending    <= 1'b0;
    end else if (dutyMove) begin
      activeDuty <= shadowDuty;
      pending    <= 1'b0;
    end else if (dutyXfer) begin
      shadowDuty <= iDUTY;
      pending    <= 1'b1;
    end
  end

`ifdef PWM_DEADTIME_EN
  localparam int DW = (CLogB2(DT_CYCLES + 1) > 0) ? CLogB2(DT_CYCLES + 1) : 1;
  localparam logic [DW-1:0] DT_MAX = DW'(DT_CYCLES);

  logic          pwmNNext;
  logic [DW-1:0] runP;
  logic [DW-1:0] runN;

  // Both raw phases are forced low in IDLE so neither output can glitch high.
  assign pwmNNext = running && !cmpHigh;

  // Each run counter holds how many consecutive previous clocks the raw phase
  // was high (saturating); the output only rises once it reaches the dead time,
  // and drops the same clock the raw phase drops.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      runP   <= '0;
      runN   <= '0;
      oPWM   <= 1'b0;
      oPWM_N <= 1'b0;
    end else begin
      oPWM   <= pwmNext && (runP >= DT_MAX);
      oPWM_N <= pwmNNext && (runN >= DT_MAX);
      if (!pwmNext) begin
        runP <= '0;
      end else if (runP < DT_MAX) begin
        runP <= runP + DW'(1);
      end
      if (!pwmNNext) begin
        runN <= '0;
      end else if (runN < DT_MAX) begin
        runN <= runN + DW'(1);
      end
    end
  end
`else
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      oPWM <= 1'b0;
    end else begin
      oPWM <= pwmNext;
    end
  end
`endif

endmodule

// File: tb/tb_pwm_seq_ctrl.sv
module tb_pwm_seq_ctrl;
  localparam int FIN = 20;
  localparam int P   = 4;
  localparam int DT  = 2;
  localparam int N   = $clog2(FIN - 1);
  localparam int L   = 2 * (FIN - 1);
`ifdef PWM_DEADTIME_EN
  localparam int DTA = DT;
`else
  localparam int DTA = 0;
`endif

  logic         iCLK = 1'b0;
  logic         iRST_n, iSTART, iSTOP, iMODE, iDUTY_VALID;
  logic [N:0]   iDUTY;
  logic [N-1:0] iCOUNT;
  logic         oDUTY_READY, oCNT_EN, oCNT_UP, oPWM, oPERIOD, oBUSY;
`ifdef PWM_DEADTIME_EN
  logic         oPWM_N;
`endif

  pwm_seq_ctrl #(.FIN_CUENTA(FIN), .PRESCALER(P), .DT_CYCLES(DT)) dut (
    .iCLK(iCLK), .iRST_n(iRST_n), .iSTART(iSTART), .iSTOP(iSTOP), .iMODE(iMODE),
    .iDUTY(iDUTY), .iDUTY_VALID(iDUTY_VALID), .oDUTY_READY(oDUTY_READY),
    .iCOUNT(iCOUNT), .oCNT_EN(oCNT_EN), .oCNT_UP(oCNT_UP), .oPWM(oPWM),
    .oPERIOD(oPERIOD), .oBUSY(oBUSY)
`ifdef PWM_DEADTIME_EN
    , .oPWM_N(oPWM_N)
`endif
  );

  always #5 iCLK = ~iCLK;

  // Attached modulo-FIN up/down counter, sharing the reset.
  always @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) iCOUNT <= '0;
    else if (oCNT_EN) begin
      if (oCNT_UP) iCOUNT <= (iCOUNT == N'(FIN - 1)) ? '0 : iCOUNT + 1'b1;
      else         iCOUNT <= (iCOUNT == '0) ? N'(FIN - 1) : iCOUNT - 1'b1;
    end
  end

  int nTests = 0;
  int nFail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      if (nFail <= 40) $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic int triCount(input int x);
    return (x <= FIN - 1) ? x : L - x;
  endfunction

  // Model: position in the waveform is derived from clocks elapsed since start.
  bit mRun, mMode, mStop, mPend;
  int mK, mAct, mShadow;
  bit pRun, pBnd;
  int pCount, pAct;
`ifdef PWM_DEADTIME_EN
  bit [DT-1:0] rHist, nHist;
`endif

  always @(negedge iCLK) begin : chk
    int t, expCount, raw, rawN;
    bit expTick, expUp, expBnd, moveNow;
    if (!iRST_n) begin
      mRun = 0; mMode = 0; mStop = 0; mPend = 0; mK = 0; mAct = 0; mShadow = 0;
      pRun = 0; pBnd = 0; pCount = 0; pAct = 0;
`ifdef PWM_DEADTIME_EN
      rHist = '0; nHist = '0;
`endif
    end
    t        = mK / P;
    expTick  = mRun && (mK % P == P - 1);
    expCount = !mRun ? 0 : (mMode ? triCount(t % L) : t % FIN);
    expUp    = !mRun || !mMode || (t % L < FIN - 1);
    expBnd   = expTick && (mMode ? (t % L == L - 1) : (t % FIN == FIN - 1));
    raw      = (pRun && pCount < pAct) ? 1 : 0;
    rawN     = (pRun && pCount >= pAct) ? 1 : 0;

    check("cnt_en", oCNT_EN, expTick);
    check("cnt_up", oCNT_UP, expUp);
    check("count", iCOUNT, expCount);
    check("period", oPERIOD, pBnd);
    check("busy", oBUSY, mRun);
    check("duty_ready", oDUTY_READY, !mPend);
`ifdef PWM_DEADTIME_EN
    check("pwm_dt", oPWM, (raw == 1) && (&rHist));
    check("pwm_n_dt", oPWM_N, (rawN == 1) && (&nHist));
    check("pwm_overlap", oPWM & oPWM_N, 0);
`else
    check("pwm", oPWM, raw);
`endif

    if (iRST_n) begin
`ifdef PWM_DEADTIME_EN
      rHist = {rHist[DT-2:0], raw[0]};
      nHist = {nHist[DT-2:0], rawN[0]};
`endif
      pRun = mRun; pCount = expCount; pAct = mAct; pBnd = expBnd;
      moveNow = mPend && (!mRun || expBnd);
      if (moveNow) begin
        mAct = mShadow; mPend = 0;
      end else if (iDUTY_VALID && !mPend) begin
        mShadow = int'(iDUTY); mPend = 1;
      end
      if (mRun) begin
        if (expBnd && mStop) begin
          mRun = 0; mStop = 0; mK = 0;
        end else begin
          if (iSTOP) mStop = 1;
          mK++;
        end
      end else if (iSTART) begin
        mRun = 1; mMode = iMODE; mK = 0;
      end
    end
  end

  task automatic step();
    @(posedge iCLK); #1;
  endtask

  task automatic writeDuty(input int d);
    iDUTY = (N+1)'(d); iDUTY_VALID = 1; step(); iDUTY_VALID = 0;
  endtask

  task automatic startRun(input bit mode);
    iMODE = mode; iSTART = 1; step(); iSTART = 0;
  endtask

  // One full period, from one oPERIOD pulse up to (not including) the next.
  task automatic measure(output int hi, output int per, output int en, output int hiN);
    int n;
    hi = 0; per = 0; en = 0; hiN = 0; n = 0;
    @(negedge iCLK);
    while (!oPERIOD && n < 400) begin @(negedge iCLK); n++; end
    check("period_start_timeout", n < 400, 1);
    do begin
      hi += int'(oPWM); en += int'(oCNT_EN); per++;
`ifdef PWM_DEADTIME_EN
      hiN += int'(oPWM_N);
`endif
      @(negedge iCLK);
    end while (!oPERIOD && per < 400);
    step();
  endtask

  task automatic waitIdle(input string name, output int n);
    n = 0;
    @(negedge iCLK);
    while (oBUSY && n < 400) begin @(negedge iCLK); n++; end
    check(name, n < 400, 1);
  endtask

  task automatic waitCount(input string name, input int v);
    int n;
    n = 0;
    @(negedge iCLK);
    while (int'(iCOUNT) != v && n < 400) begin @(negedge iCLK); n++; end
    check(name, n < 400, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int hi, per, en, hiN, n;
    iRST_n = 0; iSTART = 0; iSTOP = 0; iMODE = 0; iDUTY = '0; iDUTY_VALID = 0;
    repeat (3) step();
    @(negedge iCLK);
    check("rst_ready", oDUTY_READY, 1);
    check("rst_cnt_up", oCNT_UP, 1);
    check("rst_busy", oBUSY, 0);
    step();
    iRST_n = 1;
    step();

    // Edge mode, duty 5
    writeDuty(5);
    repeat (3) step();
    startRun(1'b0);
    measure(hi, per, en, hiN);
    check("edge_hi", hi, 20 - DTA);
    check("edge_period", per, 80);
    check("edge_ticks", en, 20);
`ifdef PWM_DEADTIME_EN
    check("edge_hi_n", hiN, 60 - DTA);
`endif

    // Stop, then center mode
    iSTOP = 1; step(); iSTOP = 0;
    waitIdle("stop1_timeout", n);
    step();
    startRun(1'b1);
    waitCount("count19_timeout", 19);
    check("center_turn_dir", oCNT_UP, 0);
    step();
    measure(hi, per, en, hiN);
    check("center_hi", hi, 36 - DTA);
    check("center_period", per, 152);
    check("center_ticks", en, 38);

    // Duty handshake mid-period
    repeat (20) step();
    iDUTY = (N+1)'(10); iDUTY_VALID = 1; step();
    iDUTY = (N+1)'(12);
    @(negedge iCLK);
    check("ready_after_write", oDUTY_READY, 0);
    n = 0;
    while (!oDUTY_READY && n < 400) begin @(negedge iCLK); n++; end
    check("ready_timeout", n < 400, 1);
    check("ready_held_long", n > 20, 1);
    check("ready_at_period", oPERIOD, 1);
    step();
    iDUTY_VALID = 0;
    measure(hi, per, en, hiN);
    check("center_duty12_hi", hi, 92 - DTA);

    // Stop at count 7 in edge mode, with ignored start and repeated stop
    iSTOP = 1; step(); iSTOP = 0;
    waitIdle("stop2_timeout", n);
    check("idle_count0", iCOUNT, 0);
    step();
    writeDuty(5);
    repeat (3) step();
    startRun(1'b0);
    waitCount("count7_timeout", 7);
    step();
    iSTOP = 1; iSTART = 1; iMODE = 1; step();
    iSTOP = 0; iSTART = 0; iMODE = 0; step();
    iSTOP = 1; step(); iSTOP = 0;
    waitIdle("stop3_timeout", n);
    check("stop_waits_boundary", n > 10, 1);
    check("stop_count0", iCOUNT, 0);
    @(negedge iCLK);
    check("stop_pwm0", oPWM, 0);
    check("stop_busy0", oBUSY, 0);
    step();
    startRun(1'b0);
    measure(hi, per, en, hiN);
    check("restart_hi", hi, 20 - DTA);
    check("restart_period", per, 80);

    // Duty 0 and duty 20
    writeDuty(0);
    measure(hi, per, en, hiN);
    check("duty0_hi", hi, 0);
    writeDuty(20);
    measure(hi, per, en, hiN);
    measure(hi, per, en, hiN);
    check("duty20_hi", hi, 80);

    // Reset mid-period
    repeat (30) step();
    iRST_n = 0;
    @(negedge iCLK);
    check("mid_rst_busy", oBUSY, 0);
    check("mid_rst_pwm", oPWM, 0);
    check("mid_rst_en", oCNT_EN, 0);
    check("mid_rst_up", oCNT_UP, 1);
    check("mid_rst_ready", oDUTY_READY, 1);
    check("mid_rst_period", oPERIOD, 0);
    step(); step();
    iRST_n = 1;
    step();
    writeDuty(5);
    repeat (3) step();
    startRun(1'b0);
    measure(hi, per, en, hiN);
    check("post_rst_hi", hi, 20 - DTA);
    check("post_rst_period", per, 80);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
